// File: rtl/comp2_pkg.sv
// Shared types and constants for the comp2 registered comparator.
package comp2_pkg;

  // One-hot compare result, bit order {G, L, E}.
  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t RES_G = 3'b100;
  localparam cmp_res_t RES_L = 3'b010;
  localparam cmp_res_t RES_E = 3'b001;

  localparam int CNT_MAX_DEFAULT = 255;

endpackage

// File: rtl/comp2_cell.sv
// comp2_cell: combinational WIDTH-bit magnitude compare, unsigned or two's complement.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module comp2_cell
  import comp2_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output cmp_res_t         res
);

  logic [WIDTH-1:0] sign_flip;
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so a single unsigned comparator serves both modes and equality is unaffected.
  assign sign_flip = WIDTH'(signed_mode) << (WIDTH - 1);
  assign a_key     = a ^ sign_flip;
  assign b_key     = b ^ sign_flip;

  always_comb begin
    res = RES_E;
    if (a_key > b_key) begin
      res = RES_G;
    end else if (a_key < b_key) begin
      res = RES_L;
    end
  end

endmodule

// File: rtl/comp2.sv
// comp2: registered one-hot compare (g/l/e) of a and b, optional saturating counters under COMP2_STATS_EN.
// Latency: 1 cycle from in_valid to out_valid; g/l/e hold their last result while idle.
// Backpressure: none, accepts one operand pair every cycle.
module comp2
  import comp2_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(CNT_MAX_DEFAULT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             g,
  output logic             l,
  output logic             e
`ifdef COMP2_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_g,
  output logic [CNT_W-1:0] cnt_l,
  output logic [CNT_W-1:0] cnt_e
`endif
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("comp2: WIDTH must be in 1..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("comp2: CNT_W must be at least 1");
  end

  cmp_res_t cell_res;
  cmp_res_t res_q;
  logic     vld_q;

  comp2_cell #(
    .WIDTH (WIDTH)
  ) u_cell (
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .res         (cell_res)
  );

  // Result only loads on a valid cycle so idle cycles keep the last compare visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        res_q <= cell_res;
      end
    end
  end

  assign out_valid = vld_q;
  assign g         = res_q[2];
  assign l         = res_q[1];
  assign e         = res_q[0];

`ifdef COMP2_STATS_EN
  logic [CNT_W-1:0] cnt_g_q;
  logic [CNT_W-1:0] cnt_l_q;
  logic [CNT_W-1:0] cnt_e_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_g_q <= '0;
      cnt_l_q <= '0;
      cnt_e_q <= '0;
    end else if (in_valid) begin
      if (cell_res == RES_G && cnt_g_q != '1) begin
        cnt_g_q <= cnt_g_q + CNT_W'(1);
      end
      if (cell_res == RES_L && cnt_l_q != '1) begin
        cnt_l_q <= cnt_l_q + CNT_W'(1);
      end
      if (cell_res == RES_E && cnt_e_q != '1) begin
        cnt_e_q <= cnt_e_q + CNT_W'(1);
      end
    end
  end

  assign cnt_g = cnt_g_q;
  assign cnt_l = cnt_l_q;
  assign cnt_e = cnt_e_q;
`endif

endmodule

// File: tb/tb_comp2.sv
// Directed bench for comp2 at WIDTH=2; counter checks run only with COMP2_STATS_EN.
module tb_comp2;

  localparam int W  = 2;
  localparam int CW = 2;

  logic         clk         = 1'b0;
  logic         rst_n       = 1'b0;
  logic         in_valid    = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a           = '0;
  logic [W-1:0] b           = '0;
  logic         out_valid;
  logic         g;
  logic         l;
  logic         e;
`ifdef COMP2_STATS_EN
  logic [CW-1:0] cnt_g;
  logic [CW-1:0] cnt_l;
  logic [CW-1:0] cnt_e;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  comp2 #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .g           (g),
    .l           (l),
    .e           (e)
`ifdef COMP2_STATS_EN
    ,
    .cnt_g       (cnt_g),
    .cnt_l       (cnt_l),
    .cnt_e       (cnt_e)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: widen to int with explicit sign handling, compare as integers.
  function automatic logic [2:0] ref_cmp(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
    int xv;
    int yv;
    xv = int'(x);
    yv = int'(y);
    if (sm && x[W-1]) xv -= (1 << W);
    if (sm && y[W-1]) yv -= (1 << W);
    if (xv > yv) return 3'b100;
    if (xv < yv) return 3'b010;
    return 3'b001;
  endfunction

  // Apply one input set, let one rising edge sample it, then settle 1 time unit.
  task automatic drive(input logic v, input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid    = v;
    signed_mode = sm;
    a           = x;
    b           = y;
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string tag, input logic [2:0] exp);
    check({tag, "/vld"}, 32'(out_valid), 32'd1);
    check({tag, "/gle"}, 32'({g, l, e}), 32'(exp));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "/vld"}, 32'(out_valid), 32'd0);
    check({tag, "/gle"}, 32'({g, l, e}), 32'd0);
`ifdef COMP2_STATS_EN
    check({tag, "/cnt"}, 32'({cnt_g, cnt_l, cnt_e}), 32'd0);
`endif
  endtask

  initial begin
    // Reset held with live, randomised inputs: nothing may leak through.
    in_valid = 1'b1;
    a        = W'($urandom);
    b        = W'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset/vld", 32'(out_valid), 32'd0);

    // Directed unsigned sequence.
    drive(1'b1, 1'b0, 2'b00, 2'b00); check_res("u_00_00", 3'b001);
    drive(1'b1, 1'b0, 2'b00, 2'b01); check_res("u_00_01", 3'b010);
    drive(1'b1, 1'b0, 2'b01, 2'b00); check_res("u_01_00", 3'b100);

    // Signed vs unsigned on the same operands.
    drive(1'b1, 1'b0, 2'b10, 2'b01); check_res("u_10_01", 3'b100);
    drive(1'b1, 1'b1, 2'b10, 2'b01); check_res("s_10_01", 3'b010);
    drive(1'b1, 1'b0, 2'b11, 2'b11); check_res("u_11_11", 3'b001);
    drive(1'b1, 1'b1, 2'b11, 2'b11); check_res("s_11_11", 3'b001);

    // Valid gap: result holds, out_valid drops, new operands ignored.
    drive(1'b1, 1'b0, 2'b01, 2'b00); check_res("gap_seed", 3'b100);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'b10, 2'b01);
      check($sformatf("gap%0d/vld", i), 32'(out_valid), 32'd0);
      check($sformatf("gap%0d/gle", i), 32'({g, l, e}), 32'b100);
    end

    // Exhaustive sweep, both modes, back-to-back.
    for (int sm = 0; sm < 2; sm++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          drive(1'b1, sm[0], W'(x), W'(y));
          check_res($sformatf("sw_m%0d_%0d_%0d", sm, x, y), ref_cmp(sm[0], W'(x), W'(y)));
          check($sformatf("onehot_m%0d_%0d_%0d", sm, x, y), 32'($countones({g, l, e})), 32'd1);
        end
      end
    end

    // Short asynchronous reset pulse between edges.
    rst_n = 1'b0;
    #1;
    check_cleared("pulse_reset");
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

`ifdef COMP2_STATS_EN
    // Saturation of the 2-bit equal counter.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 2'b10, 2'b10);
      check($sformatf("sat%0d/cnt_e", i), 32'(cnt_e), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check("sat/cnt_g", 32'(cnt_g), 32'd0);
    check("sat/cnt_l", 32'(cnt_l), 32'd0);
    check_res("sat_last", 3'b001);
`endif

    // Mid-stream reset with a valid transfer in flight: clears immediately and wins the edge.
    drive(1'b1, 1'b0, 2'b01, 2'b00); check_res("pre_mid_reset", 3'b100);
    in_valid = 1'b1;
    a        = 2'b00;
    b        = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset_async");
    @(posedge clk);
    #1;
    check_cleared("mid_reset_edge");
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 2'b01); check_res("post_reset", 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/comp2.md
# comp2

Registered magnitude comparator for two WIDTH-bit operands (default 2), producing one-hot greater/less/equal flags. It is a leaf datapath block used wherever a small compare result must be held stable for a full cycle behind a valid qualifier. Outputs are registered, with one cycle of latency, and cleared by asynchronous active-low reset.

## Interface
- WIDTH, 2: operand width in bits, legal range 1..32.
- CNT_W, 8: width of the statistics counters (used only when COMP2_STATS_EN is defined).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands are sampled on this cycle.
- signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare; sampled together with the operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  g/l/e hold a fresh result.
- g  output  1  a > b.
- l  output  1  a < b.
- e  output  1  a == b.
- cnt_g, cnt_l, cnt_e  output  CNT_W each  saturating result counters (present only with COMP2_STATS_EN).

## Operation
- On each rising clk edge with in_valid=1:
  - compute the compare of a and b, interpreting both per signed_mode;
  - register the result into g/l/e;
  - set out_valid=1.
- When the result is valid, exactly one of g/l/e is 1.
- On a clk edge with in_valid=0:
  - out_valid falls to 0;
  - g/l/e hold their last value (no result bubble into zeros).
- Signed mode: the MSB is the sign bit.
  - WIDTH=2 range: -2..1. Example: a=2'b10 (-2), b=2'b01 (1) gives l=1.
  - Unsigned mode, same operands: 2 > 1 gives g=1.
- e does not depend on signed_mode.
- Back-to-back in_valid: one result per cycle, no stalls, no backpressure.

## Timing
- Latency: 1 clock. Operands sampled at edge N appear on g/l/e/out_valid after edge N.
- Reset (rst_n=0, asynchronous assert) forces:
  - g=0, l=0, e=0, out_valid=0;
  - all counters to 0.
- Reset release is synchronous to clk. The first sampling edge is the first rising edge with rst_n=1.
- Reset asserted mid-stream discards the in-flight result.
- A reset asserted on the same edge as in_valid=1 wins.
- No combinational path from inputs to outputs.

## Configuration
- Macro COMP2_STATS_EN.
- When defined:
  - on every edge where in_valid=1, the counter matching the new result increments by 1;
  - each counter saturates at 2^CNT_W-1 and does not wrap;
  - counters clear only on reset.
- When undefined:
  - the cnt_* ports and their logic are absent;
  - the compare behaviour is identical.

## Structure
- Package comp2_pkg holds:
  - typedef cmp_res_t, a 3-bit one-hot {G, L, E};
  - constants RES_G, RES_L, RES_E;
  - helper localparam CNT_MAX_DEFAULT.
- Sub-module comp2_cell: purely combinational WIDTH-bit compare.
  - Inputs: a, b, signed_mode.
  - Output: cmp_res_t.
- The top level instantiates comp2_cell and adds the result and valid registers plus the optional counters.

## Test plan
- Reset check: drive rst_n=0 with random a/b. Required: g=l=e=0, out_valid=0; with COMP2_STATS_EN, counters are 0.
- Directed compare sequence, unsigned, WIDTH=2, in_valid=1, one pair per cycle. Each result appears one cycle later:
  - a=00, b=00 gives e=1;
  - a=00, b=01 gives l=1;
  - a=01, b=00 gives g=1.
- Signed vs unsigned: a=10, b=01.
  - signed_mode=0 gives g=1.
  - signed_mode=1 gives l=1.
  - a=11, b=11 gives e=1 in both modes.
- Valid gap: one valid pair, then in_valid=0 for 3 cycles. Required: out_valid drops to 0 and g/l/e hold.
- Exhaustive sweep: all 16 a/b pairs in both modes, checked against a reference model. Required: one-hot g/l/e on every valid output.
- Counter saturation (COMP2_STATS_EN, CNT_W=2): 5 consecutive equal pairs. Required: cnt_e=3, cnt_g=cnt_l=0. Then assert rst_n mid-stream and require all counters and outputs to clear immediately.
